// File: rtl/signed_rshift_pipe.sv
// Pipelined signed arithmetic right shift with selectable rounding.
// One barrel stage per shift-amount bit (stage k shifts by 2^k, sign-filling)
// followed by a rounding stage that forms the registered output. Guard and
// sticky bits accumulate as bits fall off the bottom of the operand.
// A single global stall (adv) freezes every stage when the output is blocked.
module signed_rshift_pipe #(
    parameter int WIDTH = 12,
    parameter int SHW   = $clog2(WIDTH),
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag
);

    localparam int NB = SHW;

    // One conditional shift step: returns {data, guard, sticky}.
    // Shifting by amt moves bit amt-1 into guard; the previous guard, the
    // previous sticky and every bit below amt-1 fold into sticky.
    function automatic logic [WIDTH+1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic             g,
        input logic             s,
        input logic             en,
        input int               amt
    );
        logic [2*WIDTH-1:0] ext;
        logic [2*WIDTH-1:0] shifted;
        logic [WIDTH-1:0]   low_mask;
        logic [WIDTH-1:0]   nd;
        logic               ng;
        logic               ns;
        ext      = {{WIDTH{d[WIDTH-1]}}, d};
        shifted  = ext >> (amt - 1);
        low_mask = ~({WIDTH{1'b1}} << (amt - 1));
        if (en) begin
            nd = shifted[WIDTH:1];
            ng = shifted[0];
            ns = s | g | (|(d & low_mask));
        end else begin
            nd = d;
            ng = g;
            ns = s;
        end
        return {nd, ng, ns};
    endfunction

    // Stage registers; v_r[NB] is the output-stage valid.
    logic [NB:0]       v_r;
    logic [WIDTH-1:0]  d_r  [NB];
    logic [NB-1:0]     g_r;
    logic [NB-1:0]     s_r;
    logic [SHW-1:0]    sh_r [NB];
    logic [1:0]        m_r  [NB];
    logic [TAGW-1:0]   t_r  [NB];
    logic [WIDTH-1:0]  out_data_r;
    logic [TAGW-1:0]   out_tag_r;

    // Stage inputs and computed next values.
    logic [WIDTH-1:0]  src_d_s  [NB];
    logic [NB-1:0]     src_g_s;
    logic [NB-1:0]     src_s_s;
    logic [SHW-1:0]    src_sh_s [NB];
    logic [1:0]        src_m_s  [NB];
    logic [TAGW-1:0]   src_t_s  [NB];
    logic [WIDTH-1:0]  nxt_d_s  [NB];
    logic [NB-1:0]     nxt_g_s;
    logic [NB-1:0]     nxt_s_s;
    logic              rnd_inc_s;
    logic [WIDTH-1:0]  rnd_data_s;
    logic              adv_s;

    assign adv_s     = ~v_r[NB] | out_ready;
    assign in_ready  = adv_s;
    assign out_valid = v_r[NB];
    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;

    // Route each barrel stage's source and apply its conditional shift.
    always_comb begin
        src_d_s[0]  = in_data;
        src_g_s[0]  = 1'b0;
        src_s_s[0]  = 1'b0;
        src_sh_s[0] = in_shamt;
        src_m_s[0]  = in_mode;
        src_t_s[0]  = in_tag;
        for (int k = 1; k < NB; k++) begin
            src_d_s[k]  = d_r[k-1];
            src_g_s[k]  = g_r[k-1];
            src_s_s[k]  = s_r[k-1];
            src_sh_s[k] = sh_r[k-1];
            src_m_s[k]  = m_r[k-1];
            src_t_s[k]  = t_r[k-1];
        end
        for (int k = 0; k < NB; k++) begin
            {nxt_d_s[k], nxt_g_s[k], nxt_s_s[k]} =
                shift_step(src_d_s[k], src_g_s[k], src_s_s[k],
                           src_sh_s[k][k], 32'sd1 << k);
        end
    end

    // Rounding increment from sign, guard, sticky and the mode.
    always_comb begin
        rnd_inc_s = 1'b0;
        case (m_r[NB-1])
            2'b01:   rnd_inc_s = d_r[NB-1][WIDTH-1] & (g_r[NB-1] | s_r[NB-1]);
            2'b10:   rnd_inc_s = d_r[NB-1][WIDTH-1] ? (g_r[NB-1] & s_r[NB-1])
                                                    : g_r[NB-1];
            default: rnd_inc_s = 1'b0;
        endcase
        rnd_data_s = d_r[NB-1] + {{(WIDTH-1){1'b0}}, rnd_inc_s};
    end

    // Pipeline advance: all stages move together or all hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r        <= '0;
            g_r        <= '0;
            s_r        <= '0;
            out_data_r <= '0;
            out_tag_r  <= '0;
            for (int k = 0; k < NB; k++) begin
                d_r[k]  <= '0;
                sh_r[k] <= '0;
                m_r[k]  <= '0;
                t_r[k]  <= '0;
            end
        end else if (adv_s) begin
            v_r        <= {v_r[NB-1:0], in_valid};
            g_r        <= nxt_g_s;
            s_r        <= nxt_s_s;
            out_data_r <= rnd_data_s;
            out_tag_r  <= t_r[NB-1];
            for (int k = 0; k < NB; k++) begin
                d_r[k]  <= nxt_d_s[k];
                sh_r[k] <= src_sh_s[k];
                m_r[k]  <= src_m_s[k];
                t_r[k]  <= src_t_s[k];
            end
        end else begin
            v_r <= v_r;
        end
    end

endmodule
